peak_gen: RTL and testbench

- Signed 16-bit triangle-wave source whose peak magnitude is set by an amplitude input.
- Generator-side counterpart of the PEAK detector: it drives the `in` of PEAK, and PEAK's `out` must read back the programmed amplitude.
- Replaces hand-written ramp stimulus in benches, and serves as an on-chip test-tone source.

---
 rtl/peak_gen_pkg.sv | 21 ++
 rtl/peak_gen_sat_step.sv | 29 ++
 rtl/peak_gen.sv | 137 +++++++++++++
 tb/tb_peak_gen.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/peak_gen_pkg.sv
// Shared types and helpers for the peak_gen triangle-wave source.

// 17-bit signed intermediate so that out +/- STEP never wraps.
`ifndef PG_S17_T
`define PG_S17_T logic signed [16:0]
`endif

package peak_gen_pkg;

    typedef logic signed [15:0] rs16_t;   // signed 16-bit request
    typedef logic signed [15:0] ws16_t;   // signed 16-bit waveform sample
    typedef `PG_S17_T s17_t;

    localparam int S16_MAX = 32767;

    // Negative amplitude requests collapse to zero so -amp_l always fits.
    function automatic rs16_t amp_clamp(input rs16_t a);
        return a[15] ? rs16_t'(0) : a;
    endfunction

endpackage

// File: rtl/peak_gen_sat_step.sv
// One saturating step of size i_step toward i_limit; o_hit flags the limit was reached.

module peak_gen_sat_step
    import peak_gen_pkg::*;
(
    input  ws16_t i_cur,
    input  logic  i_up,
    input  rs16_t i_step,
    input  rs16_t i_limit,
    output ws16_t o_next,
    output logic  o_hit
);

    s17_t w_cur;
    s17_t w_step;
    s17_t w_lim;
    s17_t w_raw;

    // Widen, step, and clamp at the limit in the direction of travel.
    always_comb begin
        w_cur  = s17_t'(i_cur);
        w_step = s17_t'(i_step);
        w_lim  = s17_t'(i_limit);
        w_raw  = i_up ? (w_cur + w_step) : (w_cur - w_step);
        o_hit  = i_up ? (w_raw >= w_lim) : (w_raw <= w_lim);
        o_next = o_hit ? i_limit : w_raw[15:0];
    end

endmodule

// File: rtl/peak_gen.sv
// Signed 16-bit triangle-wave generator with programmable peak and optional dwell.

module peak_gen
    import peak_gen_pkg::*;
#(
    parameter int STEP = 100,
    parameter int HOLD = 0
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_en,
    input  rs16_t i_amp,
    output ws16_t o_out,
    output logic  o_peak,
    output logic  o_trough,
    output logic  o_busy
);

    typedef enum logic [2:0] {
        StIdle, StRise, StHoldHi, StFall, StHoldLo, StDrain
    } state_e;

    localparam rs16_t       StepV    = rs16_t'((STEP > S16_MAX) ? S16_MAX : STEP);
    localparam bit          HasHold  = (HOLD != 0);
    localparam logic [15:0] HoldLast = HasHold ? 16'(HOLD - 1) : 16'd0;

    state_e      r_state, w_state_nxt;
    ws16_t       r_out, w_out_nxt;
    logic        r_peak, w_peak_nxt;
    logic        r_trough, w_trough_nxt;
    rs16_t       r_amp_l, w_amp_l_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;

    logic        w_drain;
    logic        w_up;
    rs16_t       w_lim;
    ws16_t       w_step_val;
    logic        w_hit;

    // Dropping en in any active state steps toward zero on that same edge.
    always_comb begin
        w_drain = (r_state == StDrain) || ((r_state != StIdle) && !i_en);
        w_up    = 1'b1;
        w_lim   = r_amp_l;
        if (w_drain) begin
            w_up  = r_out[15];
            w_lim = '0;
        end else if (r_state == StFall) begin
            w_up  = 1'b0;
            w_lim = -r_amp_l;
        end
    end

    peak_gen_sat_step u_sat_step (
        .i_cur   (r_out),
        .i_up    (w_up),
        .i_step  (StepV),
        .i_limit (w_lim),
        .o_next  (w_step_val),
        .o_hit   (w_hit)
    );

    // Next-state, next-sample and strobe logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_out_nxt    = r_out;
        w_peak_nxt   = 1'b0;
        w_trough_nxt = 1'b0;
        w_amp_l_nxt  = r_amp_l;
        w_cnt_nxt    = r_cnt;
        if (r_state == StIdle) begin
            w_out_nxt = '0;
            if (i_en) begin
                w_amp_l_nxt = amp_clamp(i_amp);
                w_state_nxt = StRise;
            end
        end else if (w_drain) begin
            w_out_nxt   = w_step_val;
            // Leave only once zero has been visible for a cycle.
            w_state_nxt = ((r_state == StDrain) && (r_out == '0)) ? StIdle : StDrain;
        end else begin
            case (r_state)
                StRise: begin
                    w_out_nxt = w_step_val;
                    if (w_hit) begin
                        w_peak_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HasHold ? StHoldHi : StFall;
                    end
                end
                StHoldHi: begin
                    if (r_cnt == HoldLast) w_state_nxt = StFall;
                    else                   w_cnt_nxt   = r_cnt + 16'd1;
                end
                StFall: begin
                    w_out_nxt = w_step_val;
                    if (w_hit) begin
                        w_trough_nxt = 1'b1;
                        w_amp_l_nxt  = amp_clamp(i_amp);
                        w_cnt_nxt    = '0;
                        w_state_nxt  = HasHold ? StHoldLo : StRise;
                    end
                end
                StHoldLo: begin
                    if (r_cnt == HoldLast) w_state_nxt = StRise;
                    else                   w_cnt_nxt   = r_cnt + 16'd1;
                end
                default: w_state_nxt = StDrain;
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_out    <= '0;
            r_peak   <= 1'b0;
            r_trough <= 1'b0;
            r_amp_l  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_peak   <= w_peak_nxt;
            r_trough <= w_trough_nxt;
            r_amp_l  <= w_amp_l_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign o_out    = r_out;
    assign o_peak   = r_peak;
    assign o_trough = r_trough;
    assign o_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_peak_gen.sv
// Directed bench for peak_gen: three parameter sets sharing one clock and reset.

module tb_peak_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic               en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic signed [15:0] amp0 = '0, amp1 = '0, amp2 = '0;
    logic signed [15:0] out0, out1, out2;
    logic               pk0, pk1, pk2, tr0, tr1, tr2, bz0, bz1, bz2;

    int total = 0;
    int bad   = 0;
    int mx    = -99999;
    int mn    = 99999;

    int seq_b1[8]  = '{100, 200, 250, 150, 50, -50, -150, -250};
    int seq_b2[8]  = '{-150, -50, 50, 150, 250, 350, 450, 550};
    int seq_b3[6]  = '{450, 350, 250, 150, 50, 0};
    int seq_d[16]  = '{100, 200, 300, 300, 300, 300, 200, 100, 0, -100, -200, -300,
                       -300, -300, -300, -200};
    int seq_e[5]   = '{32767, 0, -32767, 0, 32767};

    always #5 clk = ~clk;

    peak_gen #(.STEP(100), .HOLD(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en0), .i_amp(amp0),
        .o_out(out0), .o_peak(pk0), .o_trough(tr0), .o_busy(bz0)
    );

    peak_gen #(.STEP(100), .HOLD(3)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en1), .i_amp(amp1),
        .o_out(out1), .o_peak(pk1), .o_trough(tr1), .o_busy(bz1)
    );

    peak_gen #(.STEP(32767), .HOLD(0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_amp(amp2),
        .o_out(out2), .o_peak(pk2), .o_trough(tr2), .o_busy(bz2)
    );

    task automatic ck(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then check sample and strobes of instance u.
    task automatic tk(input int u, input string tag, input int eo, input bit ep, input bit et);
        logic signed [15:0] o;
        logic p, t;
        @(posedge clk);
        #1;
        case (u)
            0:       begin o = out0; p = pk0; t = tr0; end
            1:       begin o = out1; p = pk1; t = tr1; end
            default: begin o = out2; p = pk2; t = tr2; end
        endcase
        ck({tag, "_out"}, o, eo);
        ck({tag, "_peak"}, p, ep);
        ck({tag, "_trough"}, t, et);
        if (u == 0) begin
            if (int'(o) > mx) mx = int'(o);
            if (int'(o) < mn) mn = int'(o);
        end
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        ck("rst_out", out0, 0);
        ck("rst_busy", bz0, 0);
        ck("rst_peak", pk0, 0);
        ck("rst_trough", tr0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tk(0, "idle", 0, 0, 0);
        ck("idle_busy", bz0, 0);

        // Phase A: amp 1000, amp changed to 500 mid-rise takes effect only at the trough.
        amp0 = 16'sd1000;
        en0  = 1'b1;
        tk(0, "a_latch", 0, 0, 0);
        ck("a_latch_busy", bz0, 1);
        for (int i = 1; i <= 10; i++) begin
            tk(0, "a_rise", 100 * i, i == 10, 0);
            if (i == 5) amp0 = 16'sd500;
        end
        for (int i = 1; i <= 20; i++) tk(0, "a_fall", 1000 - 100 * i, 0, i == 20);
        ck("a_max", mx, 1000);
        ck("a_min", mn, -1000);
        for (int i = 1; i <= 15; i++) tk(0, "a_rise2", -1000 + 100 * i, i == 15, 0);
        en0 = 1'b0;
        for (int i = 1; i <= 5; i++) tk(0, "a_drain", 500 - 100 * i, 0, 0);
        ck("a_drain_busy", bz0, 1);
        tk(0, "a_idle", 0, 0, 0);
        ck("a_idle_busy", bz0, 0);

        // Phase B: amp 250 saturates mid-step; re-latch 1000 at trough, then en drop at 550.
        amp0 = 16'sd250;
        en0  = 1'b1;
        tk(0, "b_latch", 0, 0, 0);
        amp0 = 16'sd1000;
        for (int i = 0; i < 8; i++) tk(0, "b_wave", seq_b1[i], i == 2, i == 7);
        for (int i = 0; i < 8; i++) tk(0, "b_rise", seq_b2[i], 0, 0);
        en0 = 1'b0;
        for (int i = 0; i < 6; i++) tk(0, "b_drain", seq_b3[i], 0, 0);
        ck("b_drain_busy", bz0, 1);
        tk(0, "b_idle", 0, 0, 0);
        ck("b_idle_busy", bz0, 0);

        // Phase C: negative amplitude clamps to 0; peak and trough alternate.
        amp0 = -16'sd5;
        en0  = 1'b1;
        tk(0, "c_latch", 0, 0, 0);
        for (int i = 1; i <= 6; i++) tk(0, "c_alt", 0, (i % 2) == 1, (i % 2) == 0);
        en0 = 1'b0;
        tk(0, "c_drain", 0, 0, 0);
        ck("c_drain_busy", bz0, 1);
        tk(0, "c_idle", 0, 0, 0);
        ck("c_idle_busy", bz0, 0);

        // Phase D: HOLD=3 dwells four samples at each extreme.
        amp1 = 16'sd300;
        en1  = 1'b1;
        tk(1, "d_latch", 0, 0, 0);
        for (int i = 0; i < 16; i++) tk(1, "d_wave", seq_d[i], i == 2, i == 11);
        en1 = 1'b0;
        tk(1, "d_drain1", -100, 0, 0);
        tk(1, "d_drain2", 0, 0, 0);
        ck("d_drain_busy", bz1, 1);
        tk(1, "d_idle", 0, 0, 0);
        ck("d_idle_busy", bz1, 0);

        // Phase E: full-scale amplitude and step, no overflow.
        amp2 = 16'sd32767;
        en2  = 1'b1;
        tk(2, "e_latch", 0, 0, 0);
        for (int i = 0; i < 5; i++) tk(2, "e_wave", seq_e[i], (i == 0) || (i == 4), i == 2);
        en2 = 1'b0;
        tk(2, "e_drain", 0, 0, 0);
        tk(2, "e_idle", 0, 0, 0);
        ck("e_idle_busy", bz2, 0);

        // Phase F: asynchronous reset between edges while the peak strobe is high.
        amp0 = 16'sd700;
        en0  = 1'b1;
        tk(0, "f_latch", 0, 0, 0);
        for (int i = 1; i <= 7; i++) tk(0, "f_rise", 100 * i, i == 7, 0);
        #2 rst_n = 1'b0;
        #1;
        ck("f_rst_out", out0, 0);
        ck("f_rst_peak", pk0, 0);
        ck("f_rst_trough", tr0, 0);
        ck("f_rst_busy", bz0, 0);
        @(posedge clk);
        #1;
        ck("f_rst_hold_out", out0, 0);
        #2 rst_n = 1'b1;
        tk(0, "f_relatch", 0, 0, 0);
        ck("f_relatch_busy", bz0, 1);
        tk(0, "f_restart", 100, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
